// File: rtl/sp_ram_arb_pkg.sv
// sp_ram_arb_pkg: shared request/response types for the two-master RAM front end
package sp_ram_arb_pkg;
  localparam int NUM_MASTERS = 2;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;
  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;
endpackage

// File: rtl/sp_ram_arb_if.sv
// sp_ram_arb_if: req/gnt/rvalid memory port between one master and the arbiter
interface sp_ram_arb_if;
  import sp_ram_arb_pkg::*;
  logic     req;
  logic     gnt;
  mem_req_t cmd;
  mem_rsp_t rsp;
  modport master(output req, cmd, input gnt, rsp);
  modport slave(input req, cmd, output gnt, rsp);
endinterface

// File: rtl/sp_ram_arb_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, priority flips to the loser on contention
module rr_arb2
  import sp_ram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] gnt
);
  logic prio_q;
  always_ff @(posedge clk)
    if (rst) prio_q <= 1'b0;
    else if (&req) prio_q <= ~prio_q;
  always_comb gnt = rst ? 2'b00 : (&req ? (prio_q ? 2'b10 : 2'b01) : req);
endmodule

// File: rtl/sp_ram_arb.sv
// sp_ram_arb: round-robin front end sharing one single-port RAM between two masters
module sp_ram_arb
  import sp_ram_arb_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter int          NUM_WORDS  = 256,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  sp_ram_arb_if.slave           m0,
  sp_ram_arb_if.slave           m1,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);
  logic [NUM_MASTERS-1:0] gnt, rvalid;
  mem_req_t               cmd;
  logic [31:0]            off, rsp_data;
  logic                   in_rng, v_q, own_q, rd_q, err_q;
  logic [31:0]            hold_q [NUM_MASTERS];
  rr_arb2 u_arb (.clk, .rst, .req({m1.req, m0.req}), .gnt);
  always_comb begin
    cmd         = gnt[1] ? m1.cmd : m0.cmd;
    off         = cmd.addr - BASE_ADDR;
    in_rng      = off < 32'(NUM_WORDS * 4);
    ram_en_o    = |gnt && in_rng;
    ram_addr_o  = ram_en_o ? off[ADDR_WIDTH+1:2] : '0;
    ram_we_o    = ram_en_o && cmd.we;
    ram_be_o    = ram_en_o ? cmd.be : '0;
    ram_wdata_o = ram_en_o ? cmd.wdata : '0;
    // only enabled reads forward RAM data; the RAM output is garbage otherwise
    rsp_data    = rd_q ? ram_rdata_i : '0;
    rvalid      = (v_q && !rst) ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk)
    if (rst) begin
      v_q   <= 1'b0;
      own_q <= 1'b0;
      rd_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      v_q   <= |gnt;
      own_q <= gnt[1];
      rd_q  <= |gnt && in_rng && !cmd.we;
      err_q <= |gnt && !in_rng;
    end
  always_ff @(posedge clk)
    if (rst) hold_q <= '{default: '0};
    else for (int i = 0; i < NUM_MASTERS; i++) if (rvalid[i]) hold_q[i] <= rsp_data;
  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];
  assign m0.rsp = '{rvalid: rvalid[0], rdata: rvalid[0] ? rsp_data : hold_q[0], err: rvalid[0] && err_q};
  assign m1.rsp = '{rvalid: rvalid[1], rdata: rvalid[1] ? rsp_data : hold_q[1], err: rvalid[1] && err_q};
endmodule
